// File: rtl/bloom_word_ser.sv
// Word-to-byte serializer for the Bloom search byte window: takes BYTES_W-byte
// words over valid/ready and emits one byte per clock with eop marking.
module bloom_word_ser #(
    parameter  int BYTES_W = 4,
    parameter  int CNT_W   = 16,
    localparam int BW      = $clog2(BYTES_W + 1),
    localparam int IDX_W   = $clog2(BYTES_W)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [BYTES_W-1:0][7:0] word_data_i,
    input  logic                    word_val_i,
    input  logic                    word_eop_i,
    input  logic [BW-1:0]           word_bytes_i,
    output logic                    word_rdy_o,
    output logic [7:0]              data_o,
    output logic                    data_eop_o,
    output logic                    data_val_o,
    output logic [CNT_W-1:0]        pkt_cnt_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]              state_r, state_s;
    logic [BYTES_W-1:0][7:0] word_r, word_s;
    logic                    eop_r, eop_s;
    logic [IDX_W-1:0]        last_r, last_s, cnt_r, cnt_s, load_last_s;
    logic                    xfer_s;
    logic [7:0]              data_nxt_s;
    logic                    eop_nxt_s, val_nxt_s, rdy_nxt_s;
    logic [7:0]              data_r;
    logic                    data_eop_r, data_val_r, rdy_r;
    logic [CNT_W-1:0]        pkt_cnt_r;

    // Index of the final byte for an incoming word; out-of-range counts mean a full word
    always_comb begin
        load_last_s = IDX_W'(BYTES_W - 1);
        if (!word_eop_i) begin
            load_last_s = IDX_W'(BYTES_W - 1);
        end else if ((word_bytes_i == BW'(0)) || (word_bytes_i > BW'(BYTES_W))) begin
            load_last_s = IDX_W'(BYTES_W - 1);
        end else begin
            load_last_s = IDX_W'(word_bytes_i - BW'(1));
        end
    end

    // Next-state: byte index advance, word load (back-to-back on last byte), idle return
    always_comb begin
        xfer_s  = word_val_i && rdy_r;
        state_s = state_r;
        cnt_s   = cnt_r;
        word_s  = word_r;
        eop_s   = eop_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_s = ST_SEND;
                    word_s  = word_data_i;
                    eop_s   = word_eop_i;
                    last_s  = load_last_s;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cnt_r != last_r) begin
                    cnt_s = cnt_r + IDX_W'(1);
                end else if (xfer_s) begin
                    state_s = ST_SEND;
                    word_s  = word_data_i;
                    eop_s   = word_eop_i;
                    last_s  = load_last_s;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from next state so outputs can be registered
    always_comb begin
        val_nxt_s = (state_s == ST_SEND);
        rdy_nxt_s = (state_s == ST_IDLE) || (cnt_s == last_s);
        if (val_nxt_s) begin
            data_nxt_s = word_s[cnt_s];
            eop_nxt_s  = eop_s && (cnt_s == last_s);
        end else begin
            data_nxt_s = 8'h00;
            eop_nxt_s  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            word_r     <= '0;
            eop_r      <= 1'b0;
            last_r     <= '0;
            data_r     <= 8'h00;
            data_eop_r <= 1'b0;
            data_val_r <= 1'b0;
            rdy_r      <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            word_r     <= word_s;
            eop_r      <= eop_s;
            last_r     <= last_s;
            data_r     <= data_nxt_s;
            data_eop_r <= eop_nxt_s;
            data_val_r <= val_nxt_s;
            rdy_r      <= rdy_nxt_s;
        end
    end

    // Completed-packet counter, wraps naturally
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_cnt_r <= '0;
        end else if (data_val_r && data_eop_r) begin
            pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign word_rdy_o = rdy_r;
    assign data_o     = data_r;
    assign data_eop_o = data_eop_r;
    assign data_val_o = data_val_r;
    assign pkt_cnt_o  = pkt_cnt_r;

endmodule

// File: tb/tb_bloom_word_ser.sv
// Self-checking bench for bloom_word_ser: directed and random word streams
// compared against a byte-queue reference model.
module tb_bloom_word_ser;

    localparam int BYTES_W = 4;
    localparam int CNT_W   = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i = 1'b1;
    logic [BYTES_W-1:0][7:0] word_data_i = '0;
    logic                    word_val_i = 1'b0;
    logic                    word_eop_i = 1'b0;
    logic [2:0]              word_bytes_i = 3'd0;
    logic                    word_rdy_o;
    logic [7:0]              data_o;
    logic                    data_eop_o;
    logic                    data_val_o;
    logic [CNT_W-1:0]        pkt_cnt_o;

    typedef struct {logic [7:0] data; logic eop; logic rdy;} exp_t;
    typedef struct {logic val; logic eop; logic rdy; logic [7:0] data;} smp_t;

    exp_t exp_q[$];
    smp_t hist_q[$];
    int   exp_pkts = 0;
    bit   cap_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bloom_word_ser #(.BYTES_W(BYTES_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .word_data_i(word_data_i), .word_val_i(word_val_i),
        .word_eop_i(word_eop_i), .word_bytes_i(word_bytes_i),
        .word_rdy_o(word_rdy_o), .data_o(data_o), .data_eop_o(data_eop_o),
        .data_val_o(data_val_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin : cap_blk
        smp_t s;
        if (cap_en) begin
            s.val = data_val_o; s.eop = data_eop_o; s.rdy = word_rdy_o; s.data = data_o;
            hist_q.push_back(s);
        end
    end

    // Reference model: a word expands to its emitted bytes; ready is high on each word's last byte
    function automatic void model_word(logic [31:0] d, logic e, logic [2:0] b);
        int   n;
        exp_t x;
        n = (!e || b == 3'd0 || b > 3'd4) ? 4 : int'(b);
        for (int k = 0; k < n; k++) begin
            x.data = d[8*k +: 8];
            x.eop  = e && (k == n - 1);
            x.rdy  = (k == n - 1);
            exp_q.push_back(x);
        end
        if (e) exp_pkts++;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic e, input logic [2:0] b);
        bit done = 1'b0;
        word_data_i = d; word_eop_i = e; word_bytes_i = b; word_val_i = 1'b1;
        model_word(d, e, b);
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk_i);
            if (word_rdy_o) begin
                @(posedge clk_i); #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_word timeout waiting for word_rdy_o, got=0 expected=1");
            word_val_i = 1'b0;
        end
    endtask

    task automatic begin_cap();
        exp_q.delete(); hist_q.delete(); cap_en = 1'b1;
    endtask

    task automatic end_cap();
        word_val_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #1 cap_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (data_val_o !== 1'b0) begin failures++; $display("FAIL reset_val got=%b expected=0", data_val_o); end
        checks++; if (data_eop_o !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b expected=0", data_eop_o); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h expected=00", data_o); end
        checks++; if (pkt_cnt_o !== 4'd0) begin failures++; $display("FAIL reset_pkt got=%0d expected=0", pkt_cnt_o); end
        checks++; if (word_rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b expected=1", word_rdy_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_two_word();
        int vi = 0, first = -1, last = -1, zeros = 0;
        begin_cap();
        send_word(32'h4433_2211, 1'b0, 3'd0);
        send_word(32'h8877_6655, 1'b1, 3'd4);
        end_cap();
        foreach (hist_q[i]) begin
            if (hist_q[i].val) begin
                if (first < 0) first = i;
                last = i;
                checks++;
                if (vi >= exp_q.size()) begin failures++; $display("FAIL two_word extra byte got=%h", hist_q[i].data); end
                else if ({hist_q[i].data, hist_q[i].eop, hist_q[i].rdy} !== {exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy}) begin
                    failures++;
                    $display("FAIL two_word byte%0d got data=%h eop=%b rdy=%b expected data=%h eop=%b rdy=%b", vi,
                             hist_q[i].data, hist_q[i].eop, hist_q[i].rdy, exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy);
                end
                vi++;
            end else if (hist_q[i].eop) begin
                checks++; failures++; $display("FAIL two_word eop without valid got=1 expected=0");
            end
        end
        for (int i = first; i <= last && first >= 0; i++) if (!hist_q[i].val) zeros++;
        checks++; if (vi != exp_q.size()) begin failures++; $display("FAIL two_word byte count got=%0d expected=%0d", vi, exp_q.size()); end
        checks++; if (zeros != 0) begin failures++; $display("FAIL two_word valid gaps got=%0d expected=0", zeros); end
        checks++; if (pkt_cnt_o !== 4'(exp_pkts)) begin failures++; $display("FAIL two_word pkt_cnt got=%0d expected=%0d", pkt_cnt_o, 4'(exp_pkts)); end
    endtask

    task automatic test_short_eop();
        int vi = 0, first = -1, last = -1, zeros = 0;
        logic [2:0] blist [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd7};
        begin_cap();
        foreach (blist[j]) send_word(32'hDDCC_BBAA, 1'b1, blist[j]);
        end_cap();
        foreach (hist_q[i]) begin
            if (hist_q[i].val) begin
                if (first < 0) first = i;
                last = i;
                checks++;
                if (vi >= exp_q.size()) begin failures++; $display("FAIL short_eop extra byte got=%h", hist_q[i].data); end
                else if ({hist_q[i].data, hist_q[i].eop, hist_q[i].rdy} !== {exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy}) begin
                    failures++;
                    $display("FAIL short_eop byte%0d got data=%h eop=%b rdy=%b expected data=%h eop=%b rdy=%b", vi,
                             hist_q[i].data, hist_q[i].eop, hist_q[i].rdy, exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy);
                end
                vi++;
            end else if (hist_q[i].eop) begin
                checks++; failures++; $display("FAIL short_eop eop without valid got=1 expected=0");
            end
        end
        for (int i = first; i <= last && first >= 0; i++) if (!hist_q[i].val) zeros++;
        checks++; if (vi != exp_q.size()) begin failures++; $display("FAIL short_eop byte count got=%0d expected=%0d", vi, exp_q.size()); end
        checks++; if (zeros != 0) begin failures++; $display("FAIL short_eop valid gaps got=%0d expected=0", zeros); end
        checks++; if (pkt_cnt_o !== 4'(exp_pkts)) begin failures++; $display("FAIL short_eop pkt_cnt got=%0d expected=%0d", pkt_cnt_o, 4'(exp_pkts)); end
    endtask

    task automatic test_stall();
        int vi = 0, first = -1, last = -1, zeros = 0;
        bit seen = 1'b0;
        begin_cap();
        send_word(32'h1312_1110, 1'b1, 3'd4);
        word_val_i = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk_i);
            if (word_rdy_o) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL stall rdy timeout got=0 expected=1"); end
        repeat (3) @(posedge clk_i);
        #1;
        send_word(32'h2322_2120, 1'b1, 3'd3);
        end_cap();
        foreach (hist_q[i]) begin
            if (hist_q[i].val) begin
                if (first < 0) first = i;
                last = i;
                checks++;
                if (vi >= exp_q.size()) begin failures++; $display("FAIL stall extra byte got=%h", hist_q[i].data); end
                else if ({hist_q[i].data, hist_q[i].eop, hist_q[i].rdy} !== {exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy}) begin
                    failures++;
                    $display("FAIL stall byte%0d got data=%h eop=%b rdy=%b expected data=%h eop=%b rdy=%b", vi,
                             hist_q[i].data, hist_q[i].eop, hist_q[i].rdy, exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy);
                end
                vi++;
            end
        end
        for (int i = first; i <= last && first >= 0; i++) begin
            if (!hist_q[i].val) begin
                zeros++;
                checks++; if (hist_q[i].rdy !== 1'b1) begin failures++; $display("FAIL stall idle rdy got=%b expected=1", hist_q[i].rdy); end
            end
        end
        checks++; if (vi != exp_q.size()) begin failures++; $display("FAIL stall byte count got=%0d expected=%0d", vi, exp_q.size()); end
        checks++; if (zeros != 3) begin failures++; $display("FAIL stall idle cycles got=%0d expected=3", zeros); end
        checks++; if (pkt_cnt_o !== 4'(exp_pkts)) begin failures++; $display("FAIL stall pkt_cnt got=%0d expected=%0d", pkt_cnt_o, 4'(exp_pkts)); end
    endtask

    task automatic test_backpressure();
        int vi = 0, first = -1, last = -1, zeros = 0;
        begin_cap();
        send_word(32'h3433_3231, 1'b0, 3'd2);
        send_word(32'h3837_3635, 1'b0, 3'd0);
        send_word(32'h3C3B_3A39, 1'b1, 3'd2);
        end_cap();
        foreach (hist_q[i]) begin
            if (hist_q[i].val) begin
                if (first < 0) first = i;
                last = i;
                checks++;
                if (vi >= exp_q.size()) begin failures++; $display("FAIL backpressure extra byte got=%h", hist_q[i].data); end
                else if ({hist_q[i].data, hist_q[i].eop, hist_q[i].rdy} !== {exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy}) begin
                    failures++;
                    $display("FAIL backpressure byte%0d got data=%h eop=%b rdy=%b expected data=%h eop=%b rdy=%b", vi,
                             hist_q[i].data, hist_q[i].eop, hist_q[i].rdy, exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy);
                end
                vi++;
            end
        end
        for (int i = first; i <= last && first >= 0; i++) if (!hist_q[i].val) zeros++;
        checks++; if (vi != exp_q.size()) begin failures++; $display("FAIL backpressure byte count got=%0d expected=%0d", vi, exp_q.size()); end
        checks++; if (zeros != 0) begin failures++; $display("FAIL backpressure valid gaps got=%0d expected=0", zeros); end
        checks++; if (pkt_cnt_o !== 4'(exp_pkts)) begin failures++; $display("FAIL backpressure pkt_cnt got=%0d expected=%0d", pkt_cnt_o, 4'(exp_pkts)); end
    endtask

    task automatic test_random();
        int vi = 0;
        int g;
        begin_cap();
        for (int w = 0; w < 40; w++) begin
            send_word($urandom, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
            g = $urandom_range(0, 2);
            if (g > 0) begin
                word_val_i = 1'b0;
                repeat (g) @(posedge clk_i);
                #1;
            end
        end
        end_cap();
        foreach (hist_q[i]) begin
            if (hist_q[i].val) begin
                checks++;
                if (vi >= exp_q.size()) begin failures++; $display("FAIL random extra byte got=%h", hist_q[i].data); end
                else if ({hist_q[i].data, hist_q[i].eop, hist_q[i].rdy} !== {exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy}) begin
                    failures++;
                    $display("FAIL random byte%0d got data=%h eop=%b rdy=%b expected data=%h eop=%b rdy=%b", vi,
                             hist_q[i].data, hist_q[i].eop, hist_q[i].rdy, exp_q[vi].data, exp_q[vi].eop, exp_q[vi].rdy);
                end
                vi++;
            end else if (hist_q[i].eop) begin
                checks++; failures++; $display("FAIL random eop without valid got=1 expected=0");
            end
        end
        checks++; if (vi != exp_q.size()) begin failures++; $display("FAIL random byte count got=%0d expected=%0d", vi, exp_q.size()); end
        checks++; if (pkt_cnt_o !== 4'(exp_pkts)) begin failures++; $display("FAIL random pkt_cnt got=%0d expected=%0d", pkt_cnt_o, 4'(exp_pkts)); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b;
        send_word(32'h4433_2211, 1'b1, 3'd4);
        word_val_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({data_val_o, data_o} !== {1'b1, 8'h11}) begin failures++; $display("FAIL rst_mid first byte got val=%b data=%h expected val=1 data=11", data_val_o, data_o); end
        @(posedge clk_i); #2;
        rst_n_i = 1'b0;
        #1;
        checks++; if (data_val_o !== 1'b0) begin failures++; $display("FAIL rst_mid val got=%b expected=0", data_val_o); end
        checks++; if (pkt_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_mid pkt got=%0d expected=0", pkt_cnt_o); end
        checks++; if (word_rdy_o !== 1'b1) begin failures++; $display("FAIL rst_mid rdy got=%b expected=1", word_rdy_o); end
        checks++; if ({data_eop_o, data_o} !== 9'h000) begin failures++; $display("FAIL rst_mid data got eop=%b data=%h expected eop=0 data=00", data_eop_o, data_o); end
        exp_pkts = 0;
        word_data_i = 32'hA4A3_A2A1; word_eop_i = 1'b0; word_bytes_i = 3'd0; word_val_i = 1'b1;
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        word_val_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            exp_b = 8'hA1 + 8'(k);
            checks++;
            if ({data_val_o, data_eop_o, data_o} !== {1'b1, 1'b0, exp_b}) begin
                failures++;
                $display("FAIL rst_mid after release byte%0d got val=%b eop=%b data=%h expected val=1 eop=0 data=%h", k, data_val_o, data_eop_o, data_o, exp_b);
            end
        end
        @(negedge clk_i);
        checks++; if (data_val_o !== 1'b0) begin failures++; $display("FAIL rst_mid idle val got=%b expected=0", data_val_o); end
        checks++; if (pkt_cnt_o !== 4'd0) begin failures++; $display("FAIL rst_mid dropped eop pkt got=%0d expected=0", pkt_cnt_o); end
    endtask

    task automatic test_wrap();
        @(negedge clk_i) rst_n_i = 1'b0;
        exp_pkts = 0;
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        for (int p = 0; p < 15; p++) send_word(32'h0000_00F0 + 32'(p), 1'b1, 3'd1);
        word_val_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        checks++; if (pkt_cnt_o !== 4'd15) begin failures++; $display("FAIL wrap pkt15 got=%0d expected=15", pkt_cnt_o); end
        for (int p = 0; p < 2; p++) begin
            send_word(32'h0000_00E0, 1'b1, 3'd1);
            word_val_i = 1'b0;
            repeat (4) @(posedge clk_i);
            #1;
            checks++; if (pkt_cnt_o !== 4'(exp_pkts)) begin failures++; $display("FAIL wrap pkt_after_%0d got=%0d expected=%0d", 16 + p, pkt_cnt_o, 4'(exp_pkts)); end
        end
        exp_q.delete();
    endtask

    initial begin
        #3 rst_n_i = 1'b0;
        test_reset();
        test_two_word();
        test_short_eop();
        test_stall();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bloom_word_ser.md
# bloom_word_ser

Word-to-byte serializer that feeds the Bloom pattern-search byte window stage. Accepts packet data as BYTES_W-byte words over a valid/ready handshake and emits one byte per clock as a data/eop/valid byte stream, which the window stage shifts into its MAX_S-wide search window. Downstream has no backpressure, so this block owns all flow control toward the packet source.

## Interface
Parameters:
- BYTES_W, 4, bytes per input word; legal range 2..16.
- CNT_W, 16, width of the packet counter.

Ports:
- clk_i  input  1  single clock; all logic is on its rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- word_data_i  input  [BYTES_W-1:0][7:0]  input word; byte [0] is sent first.
- word_val_i  input  1  word valid.
- word_eop_i  input  1  word is the last word of the packet.
- word_bytes_i  input  $clog2(BYTES_W+1)  count of valid bytes in an eop word (bytes [0..n-1]); ignored when word_eop_i=0.
- word_rdy_o  output  1  block can accept a word this cycle.
- data_o  output  8  byte out.
- data_eop_o  output  1  byte is the last of its packet.
- data_val_o  output  1  byte valid.
- pkt_cnt_o  output  CNT_W  packets fully emitted; wraps modulo 2^CNT_W.

## Operation
- Word transfer occurs on a rising edge where word_val_i=1 and word_rdy_o=1. Source must hold word_data_i, word_eop_i and word_bytes_i stable while word_val_i=1 and word_rdy_o=0.
- State holds a word register, a stored eop flag, last_idx, and a byte index cnt.
- FSM has two states:
  - IDLE: word_rdy_o=1, data_val_o=0. A transfer loads the word, sets cnt=0, and moves to SEND.
  - SEND: data_val_o=1, data_o=word[cnt], data_eop_o=(stored eop && cnt==last_idx).
- last_idx is set on load:
  - word_eop_i=0: last_idx=BYTES_W-1.
  - word_eop_i=1: last_idx=word_bytes_i-1.
  - word_bytes_i=0 or >BYTES_W: treated as BYTES_W.
- SEND with cnt<last_idx: cnt increments and word_rdy_o=0.
- SEND with cnt==last_idx: word_rdy_o=1.
  - On a transfer in that cycle, the new word is loaded, cnt=0, and the FSM stays in SEND. There is no bubble between words.
  - With no transfer, the FSM returns to IDLE.
- pkt_cnt_o increments on each cycle where data_val_o && data_eop_o. It wraps from 2^CNT_W-1 to 0.
- Outputs are driven only from registers and a mux on registered state. There is no combinational path from word_* inputs to any data_* output.
- word_rdy_o depends only on registered state. There is no combinational path from word_val_i.

## Timing
- Reset values while rst_n_i=0, applied immediately and asynchronously:
  - FSM=IDLE, cnt=0, word register=0.
  - data_o=0, data_eop_o=0, data_val_o=0, pkt_cnt_o=0, word_rdy_o=1.
- Reset mid-packet: the held word and its remaining bytes are dropped, and no eop is emitted. After release, the block accepts a new word on the first edge.
- Latency: a word accepted at edge N puts byte [0] on data_o during the cycle after edge N. Byte [k] appears k cycles later.
- Throughput: a full word occupies exactly BYTES_W cycles. An eop word with n bytes occupies n cycles.
- Back-to-back transfers keep data_val_o continuously high across word and packet boundaries.
- data_eop_o is high for exactly one cycle per packet, coincident with data_val_o=1.
- A single-word packet with word_bytes_i=1 produces one byte with both data_val_o=1 and data_eop_o=1.
- word_eop_i=1 on a word with word_bytes_i=BYTES_W emits all bytes, with eop on byte [BYTES_W-1].

## Test plan
With BYTES_W=4:
- **Reset:** assert rst_n_i=0 mid-SEND → data_val_o=0, pkt_cnt_o=0, and word_rdy_o=1 immediately. After release, the next word's byte [0] appears one cycle after its transfer.
- **Two-word packet, continuous valid:** word A=0x44332211 (eop=0), then word B=0x88776655 (eop=1, bytes=4) → data_o sequence 11,22,33,44,55,66,77,88 on 8 consecutive valid cycles. data_eop_o is high only on 88; word_rdy_o is high only on the 22/... last-byte cycles (44 and 88); pkt_cnt_o becomes 1.
- **Short eop word:** word 0xDDCCBBAA with eop=1 and bytes=1, 2, 3 in turn → 1, 2, 3 bytes emitted with eop on AA, BB, CC respectively. bytes=0 → 4 bytes emitted, eop on DD.
- **Source stall:** word_val_i=0 for 3 cycles between two packets → data_val_o=0 for exactly those 3 cycles and FSM in IDLE. No byte is duplicated or lost.
- **Backpressure hold:** word_val_i held high with a new word while word_rdy_o=0 → the word is taken only on the last-byte cycle, and its byte [0] follows the prior last byte with no gap.
- **Counter wrap:** CNT_W=4, send 17 one-byte packets → pkt_cnt_o reads 15 then 0 then 1.
